// File: rtl/rf.sv
// RF: 32 x 32-bit register file with two combinational read ports and one
// synchronous write port. Register 0 is hardwired to zero on both read paths,
// and writes addressed to it are dropped. Reset is synchronous and clears
// every register. There is no write-to-read bypass, so a read of the register
// being written shows the old value until the clock edge.
module rf (
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    input  logic [4:0]  read_reg_1,
    input  logic [4:0]  read_reg_2,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic        regWrite,
    input  logic        clk,
    input  logic        rst
);

    logic [31:0] r_regs [32];
    logic        w_writeEn;

    // A write only takes effect when enabled and not aimed at register 0
    always_comb begin
        w_writeEn = regWrite && (write_reg != 5'd0);
    end

    // Storage update: reset clears everything and overrides any write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_writeEn) begin
            r_regs[write_reg] <= write_data;
        end
    end

    // Read ports: plain combinational lookup, register 0 forced to zero
    always_comb begin
        read_data_1 = (read_reg_1 == 5'd0) ? 32'd0 : r_regs[read_reg_1];
        read_data_2 = (read_reg_2 == 5'd0) ? 32'd0 : r_regs[read_reg_2];
    end

endmodule

// File: tb/tb_rf.sv
// Testbench for rf: reset, a table of directed write/read vectors, then
// hand-written sequences for bypass, reset priority and post-reset clearing.
module tb_rf;

    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;
    logic        clk;
    logic        rst;

    int compared;
    int mismatched;

    typedef struct {
        logic        we;
        logic [4:0]  wReg;
        logic [31:0] wData;
        logic [4:0]  rReg1;
        logic [4:0]  rReg2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vecT;

    vecT vecs [9];

    rf dut (
        .read_data_1 (readData1),
        .read_data_2 (readData2),
        .read_reg_1  (readReg1),
        .read_reg_2  (readReg2),
        .write_reg   (writeReg),
        .write_data  (writeData),
        .regWrite    (regWrite),
        .clk         (clk),
        .rst         (rst)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Drive one vector, clock it in, and settle just after the edge
    task automatic applyStimulus(input vecT v);
        regWrite  = v.we;
        writeReg  = v.wReg;
        writeData = v.wData;
        readReg1  = v.rReg1;
        readReg2  = v.rReg2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        regWrite   = 1'b0;
        writeReg   = 5'd0;
        writeData  = 32'd0;
        readReg1   = 5'd1;
        readReg2   = 5'd31;

        //              we    wReg   wData          rReg1  rReg2  exp1           exp2
        vecs[0] = '{1'b1, 5'd1,  32'd55,        5'd1,  5'd0,  32'd55,        32'd0};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF,  5'd0,  5'd0,  32'd0,         32'd0};
        vecs[2] = '{1'b1, 5'd5,  32'd7,         5'd5,  5'd1,  32'd7,         32'd55};
        vecs[3] = '{1'b0, 5'd5,  32'd99,        5'd5,  5'd5,  32'd7,         32'd7};
        vecs[4] = '{1'b1, 5'd31, 32'hDEADBEEF,  5'd31, 5'd31, 32'hDEADBEEF,  32'hDEADBEEF};
        vecs[5] = '{1'b1, 5'd2,  32'h80000000,  5'd2,  5'd31, 32'h80000000,  32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd2,  32'h00001234,  5'd2,  5'd5,  32'h00001234,  32'd7};
        vecs[7] = '{1'b1, 5'd2,  32'h0000A5A5,  5'd2,  5'd1,  32'h0000A5A5,  32'd55};
        vecs[8] = '{1'b0, 5'd0,  32'd0,         5'd3,  5'd4,  32'd0,         32'd0};

        // Initial reset for one edge
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_rd1", readData1, 32'd0);
        checkOutput("reset_rd2", readData2, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_rd1", i), readData1, vecs[i].exp1);
            checkOutput($sformatf("vec%0d_rd2", i), readData2, vecs[i].exp2);
        end

        // Read address change is seen without a clock edge
        regWrite = 1'b0;
        readReg1 = 5'd31;
        readReg2 = 5'd2;
        #1;
        checkOutput("comb_rd1", readData1, 32'hDEADBEEF);
        checkOutput("comb_rd2", readData2, 32'h0000A5A5);

        // No bypass: old value before the edge, new value after
        readReg1  = 5'd3;
        readReg2  = 5'd1;
        writeReg  = 5'd3;
        writeData = 32'd42;
        regWrite  = 1'b1;
        #1;
        checkOutput("bypass_before", readData1, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bypass_after", readData1, 32'd42);
        regWrite = 1'b0;

        // Reset priority over a simultaneous write; no async effect of rst
        readReg1  = 5'd1;
        readReg2  = 5'd5;
        rst       = 1'b1;
        regWrite  = 1'b1;
        writeReg  = 5'd1;
        writeData = 32'd9;
        #1;
        checkOutput("rst_noasync_rd1", readData1, 32'd55);
        checkOutput("rst_noasync_rd2", readData2, 32'd7);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        regWrite = 1'b0;
        checkOutput("rst_prio_rd1", readData1, 32'd0);

        // Every register reads zero on both ports after reset
        for (int a = 0; a < 32; a++) begin
            readReg1 = a[4:0];
            readReg2 = 5'(31 - a);
            #1;
            checkOutput($sformatf("clear_rd1_%0d", a), readData1, 32'd0);
            checkOutput($sformatf("clear_rd2_%0d", 31 - a), readData2, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rf.md
RF -- requirements
Module: rf

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 32 registers x 32 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 read_data_1  output  32  contents of register addressed by read_reg_1.
REQ-006 read_data_2  output  32  contents of register addressed by read_reg_2.
REQ-007 read_reg_1  input  5  read port 1 address.
REQ-008 read_reg_2  input  5  read port 2 address.
REQ-009 write_reg  input  5  write port address.
REQ-010 write_data  input  32  write port data.
REQ-011 regWrite  input  1  write enable, active-high.
REQ-012 Port declaration order SHALL be: read_data_1, read_data_2, read_reg_1, read_reg_2, write_reg, write_data, regWrite, clk, rst.
- Existing positional 8-port instantiations therefore remain valid, with rst appended last.

Function
REQ-013 The block SHALL hold 32 registers of 32 bits, indexed 0-31.
REQ-014 Register 0 SHALL always read as 32'd0.
- Writes to register 0 SHALL be silently discarded.
REQ-015 Reads SHALL be combinational (zero latency).
- read_data_N SHALL reflect the current stored value of read_reg_N.
- read_data_N SHALL update within the same cycle when the address changes.
REQ-016 On a rising clk edge with rst=0, regWrite=1 and write_reg!=0, register[write_reg] SHALL load write_data.
REQ-017 With regWrite=0, no register SHALL change.
REQ-018 No write-to-read bypass SHALL exist.
- A read of the register being written SHALL return the old value before the edge.
- The same read SHALL return the new value after the edge.
REQ-019 Both read ports SHALL be independent and SHALL be allowed to address the same register simultaneously, each returning the same value.
REQ-020 Write data SHALL be stored unmodified: no sign extension, no truncation.
REQ-021 Multiple consecutive writes to the same register SHALL leave the last written value.

Reset
REQ-022 On a rising clk edge with rst=1, all 32 registers SHALL clear to 32'd0.
REQ-023 When rst=1 and regWrite=1 at the same edge, reset SHALL take priority and the write SHALL be discarded.
REQ-024 Reset SHALL have no asynchronous effect; between edges, outputs SHALL reflect the previously stored contents.
REQ-025 After reset, both read ports SHALL output 32'd0 for every address until a write occurs.

Verification
REQ-026 Reset, then write register 1:
- Stimulus: rst=1 for one edge, then write_reg=1, write_data=55, regWrite=1 for one edge, then regWrite=0, read_reg_1=1.
- Required response: read_data_1=32'd55.
REQ-027 Register 0 write discard:
- Stimulus: write_reg=0, write_data=32'hFFFFFFFF, regWrite=1 for one edge; read_reg_2=0.
- Required response: read_data_2=32'd0.
REQ-028 Write disabled:
- Stimulus: register 5 holds 7; apply write_reg=5, write_data=99, regWrite=0 over an edge.
- Required response: read_data_1 with read_reg_1=5 stays 7.
REQ-029 No bypass:
- Stimulus: read_reg_1=3 and write_reg=3, write_data=42, regWrite=1.
- Required response: read_data_1 shows the old value before the edge and 42 after it.
REQ-030 Reset priority:
- Stimulus: register 1 holds 55; at one edge rst=1, regWrite=1, write_reg=1, write_data=9.
- Required response: register 1 reads 0.
REQ-031 Dual read, same register:
- Stimulus: write 32'hDEADBEEF to register 31; set read_reg_1=read_reg_2=31.
- Required response: both outputs equal 32'hDEADBEEF.
